// File: rtl/ibuffer_warp_sched_pkg.sv
// Shared constants and payload type for the per-warp instruction buffer.
// Decode, the buffer and issue all agree on this payload layout.
package ibuffer_warp_sched_pkg;

  localparam int NUM_WARPS = 4;
  localparam int DEPTH     = 2;
  localparam int DATAW     = 128;

  localparam int WID_W  = $clog2(NUM_WARPS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = WID_W + PTR_W;

  // Field widths add up to DATAW (32+4+32+3+4+1+32+4*5 = 128).
  typedef struct packed {
    logic [31:0] uuid;
    logic [3:0]  tmask;
    logic [31:0] pc;
    logic [2:0]  ex_type;
    logic [3:0]  op_type;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
  } payload_t;

  function automatic logic [ADDR_W-1:0] mem_addr(input logic [WID_W-1:0] wid,
                                                 input logic [PTR_W-1:0] ptr);
    return {wid, ptr};
  endfunction

endpackage

// File: rtl/ibuffer_warp_sched_if.sv
// Decode-side push, issue-side pop and per-warp control bundled for the buffer.
// The slave modport is the buffer; master is the decode/issue environment.
interface ibuffer_warp_sched_if;
  import ibuffer_warp_sched_pkg::*;

  logic                 enq_valid;
  logic [WID_W-1:0]     enq_wid;
  payload_t             enq_data;
  logic                 enq_ready;

  logic                 deq_valid;
  logic [WID_W-1:0]     deq_wid;
  payload_t             deq_data;
  logic                 deq_ready;

  logic [NUM_WARPS-1:0] warp_block;
  logic                 flush_valid;
  logic [WID_W-1:0]     flush_wid;
  logic [NUM_WARPS-1:0] warp_empty;

  modport slave (
    input  enq_valid, enq_wid, enq_data,
    output enq_ready,
    output deq_valid, deq_wid, deq_data,
    input  deq_ready,
    input  warp_block, flush_valid, flush_wid,
    output warp_empty
  );

  modport master (
    output enq_valid, enq_wid, enq_data,
    input  enq_ready,
    input  deq_valid, deq_wid, deq_data,
    output deq_ready,
    output warp_block, flush_valid, flush_wid,
    input  warp_empty
  );

endinterface

// File: rtl/ibuffer_warp_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last grant, wrapping.
// The last-grant register only advances when the grant is actually used (en_i).
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand;

  // NOTE: combinational blocks use blocking '=' so later statements see earlier
  // results; every output gets a default first so no latch is inferred.
  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    // N is a power of two, so IDX_W-bit addition wraps the search naturally.
    for (int i = 1; i <= N; i++) begin
      cand = last_q + IDX_W'(i);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
    grant_oh_o = grant_valid_o ? (N'(1) << grant_idx_o) : '0;
    last_d     = (en_i && grant_valid_o) ? grant_idx_o : last_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) last_q <= IDX_W'(N - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/ibuffer_warp_sched.sv
// Per-warp circular instruction queues feeding a round-robin scheduled,
// registered issue output, with per-warp flush and block control.
module ibuffer_warp_sched
  import ibuffer_warp_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  ibuffer_warp_sched_if.slave  bus
);

  logic [CNT_W-1:0]     cnt    [NUM_WARPS];
  logic [PTR_W-1:0]     rd_ptr [NUM_WARPS];
  logic [PTR_W-1:0]     wr_ptr [NUM_WARPS];
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] empty;

  logic                 push, pop, load, drop_out;
  logic [NUM_WARPS-1:0] grant_oh;
  logic [WID_W-1:0]     grant_idx;
  logic                 grant_valid;
  payload_t             rd_data;

  payload_t             mem_q [NUM_WARPS*DEPTH];

  logic                 deq_valid_q, deq_valid_d;
  logic [WID_W-1:0]     deq_wid_q,   deq_wid_d;
  payload_t             deq_data_q,  deq_data_d;

  assign bus.enq_ready = (cnt[bus.enq_wid] != CNT_W'(DEPTH)) &&
                         !(bus.flush_valid && (bus.flush_wid == bus.enq_wid));
  assign push = bus.enq_valid && bus.enq_ready;

  // A flushed entry stuck in the output register is treated as a free slot.
  assign drop_out = bus.flush_valid && deq_valid_q &&
                    (bus.flush_wid == deq_wid_q) && !bus.deq_ready;
  assign load = !deq_valid_q || bus.deq_ready || drop_out;
  assign pop  = load && grant_valid;

  rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .clk           (clk),
    .reset         (reset),
    .req_i         (eligible),
    .en_i          (pop),
    .grant_oh_o    (grant_oh),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    localparam logic [WID_W-1:0] W = WID_W'(w);

    logic             push_w, pop_w, flush_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    assign push_w  = push && (bus.enq_wid == W);
    assign pop_w   = pop && grant_oh[w];
    assign flush_w = bus.flush_valid && (bus.flush_wid == W);

    assign cnt_d    = cnt_q + CNT_W'(push_w) - CNT_W'(pop_w);
    assign rd_ptr_d = pop_w  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign wr_ptr_d = push_w ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    always_ff @(posedge clk) begin
      if (reset || flush_w) begin
        cnt_q    <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        cnt_q    <= cnt_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
      end
    end

    assign cnt[w]      = cnt_q;
    assign rd_ptr[w]   = rd_ptr_q;
    assign wr_ptr[w]   = wr_ptr_q;
    assign empty[w]    = (cnt_q == '0);
    assign eligible[w] = !empty[w] && !bus.warp_block[w] && !flush_w;
  end

  assign bus.warp_empty = empty;

  // NOTE: the storage array has no reset; counts gate every read, so stale
  // entries are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[mem_addr(bus.enq_wid, wr_ptr[bus.enq_wid])] <= bus.enq_data;
  end

  assign rd_data = mem_q[mem_addr(grant_idx, rd_ptr[grant_idx])];

  always_comb begin
    deq_valid_d = deq_valid_q;
    deq_wid_d   = deq_wid_q;
    deq_data_d  = deq_data_q;
    if (load) begin
      deq_valid_d = grant_valid;
      if (grant_valid) begin
        deq_wid_d  = grant_idx;
        deq_data_d = rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deq_valid_q <= 1'b0;
      deq_wid_q   <= '0;
      deq_data_q  <= '0;
    end else begin
      deq_valid_q <= deq_valid_d;
      deq_wid_q   <= deq_wid_d;
      deq_data_q  <= deq_data_d;
    end
  end

  assign bus.deq_valid = deq_valid_q;
  assign bus.deq_wid   = deq_wid_q;
  assign bus.deq_data  = deq_data_q;

endmodule

// File: tb/tb_ibuffer_warp_sched.sv
// Cycle-table bench for ibuffer_warp_sched: each row is one cycle of inputs
// and the outputs expected in that same cycle, plus a reset-mid-run sequence.
module tb_ibuffer_warp_sched;
  import ibuffer_warp_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ibuffer_warp_sched_if bus ();

  ibuffer_warp_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       ev;
    int         ew;
    int         tok;
    logic       rdy;
    logic [3:0] blk;
    logic       fv;
    int         fw;
    logic       x_erdy;
    logic       x_dv;
    int         x_dw;
    int         x_tok;
    logic [3:0] x_emp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DATAW-1:0] mk(input int tok);
    logic [7:0] b;
    b = 8'(tok);
    return {16{b}};
  endfunction

  function automatic vec_t v(input logic ev, input int ew, input int tok, input logic rdy,
                             input logic [3:0] blk, input logic fv, input int fw,
                             input logic x_erdy, input logic x_dv, input int x_dw,
                             input int x_tok, input logic [3:0] x_emp);
    vec_t r;
    r.ev = ev; r.ew = ew; r.tok = tok; r.rdy = rdy; r.blk = blk; r.fv = fv; r.fw = fw;
    r.x_erdy = x_erdy; r.x_dv = x_dv; r.x_dw = x_dw; r.x_tok = x_tok; r.x_emp = x_emp;
    return r;
  endfunction

  task automatic check(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input int ew, input int tok, input logic rdy,
                       input logic [3:0] blk, input logic fv, input int fw);
    bus.enq_valid   = ev;
    bus.enq_wid     = WID_W'(ew);
    bus.enq_data    = mk(tok);
    bus.deq_ready   = rdy;
    bus.warp_block  = blk;
    bus.flush_valid = fv;
    bus.flush_wid   = WID_W'(fw);
  endtask

  task automatic check_out(input string tag, input logic dv, input int dw, input int tok,
                           input logic [3:0] emp);
    check({tag, "_deq_valid"}, DATAW'(bus.deq_valid), DATAW'(dv));
    check({tag, "_warp_empty"}, DATAW'(bus.warp_empty), DATAW'(emp));
    if (dv) begin
      check({tag, "_deq_wid"}, DATAW'(bus.deq_wid), DATAW'(dw));
      check({tag, "_deq_data"}, bus.deq_data, mk(tok));
    end
  endtask

  initial begin
    // Dequeue of w0 two cycles after push; back-to-back drain.
    vecs.push_back(v(1,0,'h01,1,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    vecs.push_back(v(1,0,'h02,1,4'b0000,0,0, 1,0,0,'h00,4'b1110));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,0,'h01,4'b1110));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,0,'h02,4'b1111));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    // One per warp while issue stalls, then round-robin drain w1,w2,w3.
    vecs.push_back(v(1,0,'h10,0,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    vecs.push_back(v(1,1,'h11,0,4'b0000,0,0, 1,0,0,'h00,4'b1110));
    vecs.push_back(v(1,2,'h12,0,4'b0000,0,0, 1,1,0,'h10,4'b1101));
    vecs.push_back(v(1,3,'h13,0,4'b0000,0,0, 1,1,0,'h10,4'b1001));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,0,'h10,4'b0001));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,1,'h11,4'b0011));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,2,'h12,4'b0111));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,3,'h13,4'b1111));
    // w1 x2, w3 x2 -> w1,w3,w1,w3; w3 full shows enq_ready=0.
    vecs.push_back(v(1,1,'h21,0,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    vecs.push_back(v(1,1,'h22,0,4'b0000,0,0, 1,0,0,'h00,4'b1101));
    vecs.push_back(v(1,3,'h31,0,4'b0000,0,0, 1,1,1,'h21,4'b1101));
    vecs.push_back(v(1,3,'h32,0,4'b0000,0,0, 1,1,1,'h21,4'b0101));
    vecs.push_back(v(0,3,'h00,1,4'b0000,0,0, 0,1,1,'h21,4'b0101));
    vecs.push_back(v(0,3,'h00,1,4'b0000,0,0, 1,1,3,'h31,4'b0101));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,1,'h22,4'b0111));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,3,'h32,4'b1111));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    // Fill blocked w2 to DEPTH; third push refused, w1 still accepted.
    vecs.push_back(v(1,2,'h41,0,4'b0100,0,0, 1,0,0,'h00,4'b1111));
    vecs.push_back(v(1,2,'h42,0,4'b0100,0,0, 1,0,0,'h00,4'b1011));
    vecs.push_back(v(1,2,'h43,0,4'b0100,0,0, 0,0,0,'h00,4'b1011));
    vecs.push_back(v(1,1,'h44,0,4'b0100,0,0, 1,0,0,'h00,4'b1011));
    vecs.push_back(v(0,2,'h00,0,4'b0100,0,0, 0,0,0,'h00,4'b1001));
    vecs.push_back(v(0,2,'h00,1,4'b0000,0,0, 0,1,1,'h44,4'b1011));
    vecs.push_back(v(0,2,'h00,0,4'b0000,0,0, 1,1,2,'h41,4'b1011));
    // Stall with w1 queued: output, data and w1 count stay put.
    vecs.push_back(v(1,1,'h51,0,4'b0000,0,0, 1,1,2,'h41,4'b1011));
    for (int k = 0; k < 4; k++)
      vecs.push_back(v(0,1,'h00,0,4'b0000,0,0, 1,1,2,'h41,4'b1001));
    vecs.push_back(v(0,1,'h00,1,4'b0000,0,0, 1,1,2,'h41,4'b1001));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,1,'h51,4'b1011));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,2,'h42,4'b1111));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    // Flush w3 while output holds w3 and issue stalls; same-cycle enq refused.
    vecs.push_back(v(1,3,'h61,0,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    vecs.push_back(v(1,3,'h62,0,4'b0000,0,0, 1,0,0,'h00,4'b0111));
    vecs.push_back(v(1,3,'h63,0,4'b0000,1,3, 0,1,3,'h61,4'b0111));
    vecs.push_back(v(0,3,'h00,0,4'b0000,1,0, 1,0,0,'h00,4'b1111));
    // Flush w0 while output holds w0 and issue accepts: transfer completes.
    vecs.push_back(v(1,0,'h71,0,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    vecs.push_back(v(1,0,'h72,0,4'b0000,0,0, 1,0,0,'h00,4'b1110));
    vecs.push_back(v(0,0,'h00,1,4'b0000,1,0, 0,1,0,'h71,4'b1110));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,0,0,'h00,4'b1111));
    // Block w0: only w1 issues; release lets w0 issue.
    vecs.push_back(v(1,0,'h81,0,4'b0001,0,0, 1,0,0,'h00,4'b1111));
    vecs.push_back(v(1,1,'h82,0,4'b0001,0,0, 1,0,0,'h00,4'b1110));
    vecs.push_back(v(0,0,'h00,1,4'b0001,0,0, 1,0,0,'h00,4'b1100));
    vecs.push_back(v(0,0,'h00,1,4'b0001,0,0, 1,1,1,'h82,4'b1110));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,0,0,'h00,4'b1110));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,1,0,'h81,4'b1111));
    vecs.push_back(v(0,0,'h00,1,4'b0000,0,0, 1,0,0,'h00,4'b1111));

    reset = 1'b1;
    drive(0,0,0,0,4'b0000,0,0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_deq_valid", DATAW'(bus.deq_valid), '0);
    check("rst_deq_wid", DATAW'(bus.deq_wid), '0);
    check("rst_deq_data", bus.deq_data, '0);
    check("rst_warp_empty", DATAW'(bus.warp_empty), DATAW'(4'b1111));
    check("rst_enq_ready", DATAW'(bus.enq_ready), DATAW'(1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ev, vecs[i].ew, vecs[i].tok, vecs[i].rdy, vecs[i].blk, vecs[i].fv, vecs[i].fw);
      #1;
      check($sformatf("v%0d_enq_ready", i), DATAW'(bus.enq_ready), DATAW'(vecs[i].x_erdy));
      check_out($sformatf("v%0d", i), vecs[i].x_dv, vecs[i].x_dw, vecs[i].x_tok, vecs[i].x_emp);
    end

    // Reset mid-run drops queue and output, and restores warp 0 priority.
    @(negedge clk); drive(1,2,'h91,0,4'b0000,0,0);
    @(negedge clk); drive(1,2,'h92,0,4'b0000,0,0);
    @(negedge clk); drive(0,0,'h00,0,4'b0000,0,0);
    #1; check_out("mid_pre", 1, 2, 'h91, 4'b1011);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    check("mid_rst_deq_wid", DATAW'(bus.deq_wid), '0);
    check("mid_rst_deq_data", bus.deq_data, '0);
    check_out("mid_rst", 0, 0, 0, 4'b1111);
    @(negedge clk); drive(1,3,'hb3,0,4'b1001,0,0);
    @(negedge clk); drive(1,0,'hb0,0,4'b1001,0,0);
    @(negedge clk); drive(0,0,'h00,0,4'b0000,0,0);
    #1; check_out("rr_reset_pre", 0, 0, 0, 4'b0110);
    @(negedge clk); drive(0,0,'h00,1,4'b0000,0,0);
    #1; check_out("rr_reset_w0", 1, 0, 'hb0, 4'b0111);
    @(negedge clk);
    #1; check_out("rr_reset_w3", 1, 3, 'hb3, 4'b1111);
    @(negedge clk); drive(0,0,'h00,0,4'b0000,0,0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
